// File: rtl/lfsr8_checker.sv
// Serial PRBS checker for the 8-bit Fibonacci LFSR (x8^x6^x5^x3): self-syncs, locks, then flywheels and counts errors.
// Optional macro LFSR8_CHK_BITCNT_EN adds a saturating bit_count of valid bits sampled while locked.
module lfsr8_checker #(
  parameter int LOCK_CNT    = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
`ifdef LFSR8_CHK_BITCNT_EN
  ,
  output logic [CNT_W-1:0] bit_count
`endif
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [1:0] {SEED, HUNT, LOCKED} state_t;

  state_t           state, state_n;
  logic [8:1]       s, s_n, s_sh;
  logic [3:0]       fill, fill_n;
  logic [MW-1:0]    match_cnt, match_n;
  logic [UW-1:0]    miss_cnt, miss_n;
  logic             locked_n, err_n;
  logic [CNT_W-1:0] cnt_n;
  logic             pred, mismatch, shift_bit;
`ifdef LFSR8_CHK_BITCNT_EN
  logic [CNT_W-1:0] bcnt_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEED;
      s         <= '0;
      fill      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
`ifdef LFSR8_CHK_BITCNT_EN
      bit_count <= '0;
`endif
    end else begin
      state     <= state_n;
      s         <= s_n;
      fill      <= fill_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      locked    <= locked_n;
      err       <= err_n;
      err_count <= cnt_n;
`ifdef LFSR8_CHK_BITCNT_EN
      bit_count <= bcnt_n;
`endif
    end
  end

  always_comb begin
    pred      = s[8] ^ s[6] ^ s[5] ^ s[3];
    mismatch  = bit_in ^ pred;
    // Once locked the register flywheels on its own prediction, so line errors never corrupt it.
    shift_bit = (state == LOCKED) ? pred : bit_in;
    s_sh      = {s[7:1], shift_bit};
    state_n   = state;
    s_n       = s;
    fill_n    = fill;
    match_n   = match_cnt;
    miss_n    = miss_cnt;
    locked_n  = locked;
    err_n     = 1'b0;
    cnt_n     = err_count;
`ifdef LFSR8_CHK_BITCNT_EN
    bcnt_n    = bit_count;
`endif
    if (bit_valid) begin
      s_n = s_sh;
      case (state)
        SEED: begin
          fill_n = (fill == 4'd8) ? 4'd8 : fill + 4'd1;
          if (fill_n == 4'd8 && s_sh != '0) begin
            state_n = HUNT;
            match_n = '0;
          end
        end
        HUNT: begin
          if (s_sh == '0) begin
            state_n = SEED;
            fill_n  = '0;
            match_n = '0;
          end else if (!mismatch) begin
            if (match_cnt == MW'(LOCK_CNT - 1)) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
              match_n  = '0;
              miss_n   = '0;
            end else begin
              match_n = match_cnt + 1'b1;
            end
          end else begin
            match_n = '0;
          end
        end
        LOCKED: begin
`ifdef LFSR8_CHK_BITCNT_EN
          if (bit_count != '1) bcnt_n = bit_count + 1'b1;
`endif
          if (mismatch) begin
            err_n = 1'b1;
            if (err_count != '1) cnt_n = err_count + 1'b1;
            if (miss_cnt == UW'(UNLOCK_ERRS - 1)) begin
              state_n  = SEED;
              fill_n   = '0;
              miss_n   = '0;
              locked_n = 1'b0;
            end else begin
              miss_n = miss_cnt + 1'b1;
            end
          end else begin
            miss_n = '0;
          end
        end
        default: state_n = SEED;
      endcase
    end
    if (clr_cnt) begin
      cnt_n = '0;
`ifdef LFSR8_CHK_BITCNT_EN
      bcnt_n = '0;
`endif
    end
  end

endmodule

// File: tb/tb_lfsr8_checker.sv
// Bench for lfsr8_checker: directed scenarios plus random traffic against a queue-based reference model.
module tb_lfsr8_checker;
  localparam int CW   = 4;
  localparam int LC   = 16;
  localparam int UE   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, rst = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, clr_cnt = 1'b0;
  logic locked, err;
  logic [CW-1:0] err_count;
`ifdef LFSR8_CHK_BITCNT_EN
  logic [CW-1:0] bit_count;
`endif

  int checks = 0, failures = 0;

  lfsr8_checker #(.LOCK_CNT(LC), .UNLOCK_ERRS(UE), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_count(err_count)
`ifdef LFSR8_CHK_BITCNT_EN
    , .bit_count(bit_count)
`endif
  );

  always #5 clk = ~clk;

  // Generator: stream obeys b[n] = b[n-8]^b[n-6]^b[n-5]^b[n-3]
  bit gen_hist[$];
  task automatic gen_seed(input bit [7:0] seed);
    gen_hist = {};
    for (int i = 7; i >= 0; i--) gen_hist.push_back(seed[i]);
  endtask
  task automatic gen_next(output bit b);
    int n;
    n = gen_hist.size();
    b = gen_hist[n-8] ^ gen_hist[n-6] ^ gen_hist[n-5] ^ gen_hist[n-3];
    gen_hist.push_back(b);
    void'(gen_hist.pop_front());
  endtask

  // Reference model: window of the last 8 accepted bits, oldest first
  int m_mode, m_fill, m_run, m_miss, m_cnt, m_bcnt;
  bit m_locked, m_err;
  bit win[$];

  task automatic m_reset();
    m_mode = 0; m_fill = 0; m_run = 0; m_miss = 0; m_cnt = 0; m_bcnt = 0;
    m_locked = 0; m_err = 0;
    win = {};
    for (int i = 0; i < 8; i++) win.push_back(1'b0);
  endtask

  task automatic m_step(input bit b, input bit v, input bit c);
    bit p, nz;
    m_err = 0;
    if (v) begin
      p = win[0] ^ win[2] ^ win[3] ^ win[5];
      win.push_back(m_mode == 2 ? p : b);
      void'(win.pop_front());
      nz = 0;
      foreach (win[i]) nz |= win[i];
      if (m_mode == 0) begin
        if (m_fill < 8) m_fill++;
        if (m_fill == 8 && nz) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
        if (!nz) begin m_mode = 0; m_fill = 0; m_run = 0; end
        else if (b == p) begin
          m_run++;
          if (m_run == LC) begin m_mode = 2; m_locked = 1; m_run = 0; m_miss = 0; end
        end else m_run = 0;
      end else begin
        if (m_bcnt < CMAX) m_bcnt++;
        if (b != p) begin
          m_err = 1;
          if (m_cnt < CMAX) m_cnt++;
          m_miss++;
          if (m_miss == UE) begin m_mode = 0; m_fill = 0; m_miss = 0; m_locked = 0; end
        end else m_miss = 0;
      end
    end
    if (c) begin m_cnt = 0; m_bcnt = 0; end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_model();
    chk("model_locked", 32'(locked), 32'(m_locked));
    chk("model_err", 32'(err), 32'(m_err));
    chk("model_err_count", 32'(err_count), m_cnt);
`ifdef LFSR8_CHK_BITCNT_EN
    chk("model_bit_count", 32'(bit_count), m_bcnt);
`endif
  endtask

  // One clock: drive at negedge, sample edge, compare 1ns later
  task automatic send(input bit flip, input bit v, input bit c);
    bit b;
    @(negedge clk);
    if (v) begin gen_next(b); b ^= flip; end
    else b = 1'($urandom);
    bit_in = b; bit_valid = v; clr_cnt = c;
    @(posedge clk);
    m_step(b, v, c);
    #1 chk_model();
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; bit_valid = 1'b0; clr_cnt = 1'b0;
    m_reset();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic lock_check(input string tag);
    for (int i = 1; i <= 24; i++) begin
      send(0, 1, 0);
      if (i == 23) chk({tag, "_not_yet"}, 32'(locked), 0);
    end
    chk(tag, 32'(locked), 1);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_count", 32'(err_count), 0);
    rst = 1'b0;

    // Clean lock from seed FF
    gen_seed(8'hFF);
    lock_check("clean_lock_24");
    chk("clean_err_count", 32'(err_count), 0);

`ifdef LFSR8_CHK_BITCNT_EN
    repeat (7) send(0, 1, 0);
    chk("bitcnt_7", 32'(bit_count), 7);
    send(0, 1, 1);
    chk("bitcnt_clr", 32'(bit_count), 0);
`endif

    // Single error
    send(0, 1, 1);
    repeat (5) send(0, 1, 0);
    send(1, 1, 0);
    chk("single_err_pulse", 32'(err), 1);
    chk("single_err_count", 32'(err_count), 1);
    send(0, 1, 0);
    chk("single_err_gone", 32'(err), 0);
    repeat (20) send(0, 1, 0);
    chk("single_still_locked", 32'(locked), 1);
    chk("single_count_held", 32'(err_count), 1);

    // Loss of lock then relock
    send(0, 1, 1);
    for (int i = 1; i <= 4; i++) begin
      send(1, 1, 0);
      chk("loss_err_pulse", 32'(err), 1);
      if (i == 3) chk("loss_locked_before_4th", 32'(locked), 1);
    end
    chk("loss_err_count", 32'(err_count), 4);
    chk("loss_unlocked", 32'(locked), 0);
    lock_check("relock_24");

    // Saturation and clear on an error cycle
    for (int i = 0; i < 20; i++) begin
      repeat (4) send(0, 1, 0);
      send(1, 1, 0);
    end
    chk("sat_count", 32'(err_count), 15);
    chk("sat_locked", 32'(locked), 1);
    repeat (4) send(0, 1, 0);
    send(1, 1, 1);
    chk("clr_on_err_pulse", 32'(err), 1);
    chk("clr_on_err_count", 32'(err_count), 0);

    // Reset while locked with err high
    send(0, 1, 0);
    send(1, 1, 0);
    chk("pre_rst_err", 32'(err), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_locked", 32'(locked), 0);
    chk("async_rst_err", 32'(err), 0);
    chk("async_rst_count", 32'(err_count), 0);
    m_reset();
    @(negedge clk); rst = 1'b0;

    // Lock-up pattern: zeros never leave SEED
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); bit_in = 1'b0; bit_valid = 1'b1; clr_cnt = 1'b0;
      @(posedge clk); m_step(1'b0, 1'b1, 1'b0);
      #1 chk_model();
    end
    chk("zeros_unlocked", 32'(locked), 0);
    chk("zeros_count", 32'(err_count), 0);

    // Gapped stream: lock counts valid bits, not cycles
    do_reset();
    gen_seed(8'($urandom_range(1, 255)));
    for (int i = 1; i <= 24; i++) begin
      send(0, 1, 0);
      if (i == 23) chk("gap_not_yet", 32'(locked), 0);
      send(0, 0, 0);
      chk("gap_idle_err", 32'(err), 0);
    end
    chk("gap_lock_24_valid", 32'(locked), 1);

    // Random traffic against the model
    do_reset();
    gen_seed(8'($urandom_range(1, 255)));
    for (int i = 0; i < 600; i++) begin
      bit v, f, c;
      v = ($urandom_range(0, 3) != 0);
      f = v && ($urandom_range(0, 24) == 0);
      c = ($urandom_range(0, 60) == 0);
      send(f, v, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
